alu_mdu_controller: RTL and testbench
=====================================

# alu_mdu_controller

Next-generation execute-stage controller for the MIPS core. It extends the combinational opcode/funct → ALU command decode to the full integer R/I set, parametrised in datapath width. It adds an iterative multiply/divide unit with HI/LO registers, a busy state machine and a pipeline stall, and sits between instruction decode and the ALU/register-file write-back path.

## Interface
- XLEN, 32, datapath width (≥4, even).
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  an instruction is presented this cycle.
- opcode  in  opcode_t (6)  instruction opcode.
- funct  in  funct_t (6)  R-type function field.
- rs_val  in  XLEN  rs operand.
- rt_val  in  XLEN  rt operand.
- flush  in  1  abort any in-flight mul/div; ignore this cycle's instruction.
- alu_cmd_out  out  alu_cmd_t  ALU command, combinational from opcode/funct.
- stall  out  1  hold the PC; the presented instruction is not accepted.
- busy  out  1  mul/div in flight.
- hilo_rd_data  out  XLEN  HI (mfhi) or LO (mflo) value, valid when valid_in and not stall.

## Operation
- ALU decode, independent of valid_in; everything else → NONE:
  - R: 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - I: 0x08/0x09 ADD; 0x0A SLT; 0x0B SLTU; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0F LUI.
- MDU ops (opcode 0): 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo.
- Stall rule: stall = valid_in & busy & (instruction is any MDU op) & ~flush. Non-MDU instructions never stall.
- FSM states:
  - IDLE → RUN on an accepted mult/div; operands are latched as magnitudes, with result-sign flags recorded; counter = XLEN−1.
  - RUN: one bit per cycle; shift-add over a 2·XLEN accumulator (mul), restoring divide (div). Counter 0 → FIX.
  - FIX: conditional negation, then HI/LO written at end of cycle → IDLE.
- Signed results:
  - Product is negative iff operand signs differ.
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
- Result placement: mul HI = upper half, LO = lower half; div LO = quotient, HI = remainder.
- Divide by zero: IDLE → FIX directly with HI = rs_val, LO = all ones.
- Signed min / −1: LO = 0x8000_0000 (for XLEN=32), HI = 0.
- mthi/mtlo accepted in IDLE: HI/LO write at that edge.
- hilo_rd_data: mfhi selects HI, mflo selects LO (combinational from registers); 0 otherwise.
- flush: from any state → IDLE at next edge; HI/LO unchanged; the presented instruction is not accepted.

## Timing
- Reset: state IDLE, HI = LO = 0, counter 0, busy 0; stall 0 (follows busy); hilo_rd_data = 0.
- Accept mult/div at cycle T:
  - busy high T+1 … T+XLEN+1 (RUN T+1…T+XLEN, FIX T+XLEN+1).
  - HI/LO valid from T+XLEN+2, giving latency XLEN+2.
- Div by zero: busy high only at T+1; result readable at T+2.
- MDU op at T+1…T+XLEN+1 stalls; the first accepted cycle is T+XLEN+2.
- mthi at T → mfhi at T+1 reads the new value.
- flush or rst_n low mid-RUN: busy drops the next cycle (or immediately, for reset); no HI/LO write.
- Simultaneous flush and new mult in IDLE: flush wins; no start.

## Structure
- ALUType: alu_cmd_t gains XOR, NOR, SLT, SLTU, SRA, LUI.
- CPUType: mdu_op_t (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, NONE) and the funct/opcode constants above.
- Sub-module mdu_iter: XLEN-parametrised iterative multiply/divide datapath (accumulator, counter, sign fix). The controller owns decode, FSM, stall and HI/LO.

## Test plan
- Decode: opcode 0/funct 0x27 → NOR; opcode 0x0F → LUI; opcode 0/funct 0x18 → NONE; opcode 0x3F → NONE.
- mult 0xFFFF_FFFD × 7 at T: mflo at T+1 stalls through T+33; at T+34 it reads 0xFFFF_FFEB and HI = 0xFFFF_FFFF.
- divu 100/7 → LO = 14, HI = 2; div −7/2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- div 5/0: busy one cycle; HI = 5, LO = 0xFFFF_FFFF at T+2.
- Preload HI = 0xA5 via mthi, start mult, flush at T+10: busy low at T+11 and HI still 0xA5. Repeat with rst_n low at T+10: HI = LO = 0.
- XLEN=8: multu 0xFF×0xFF → HI = 0xFE, LO = 0x01 readable 10 cycles after accept.

Source files
------------

// File: rtl/alu_mdu_controller_pkg.sv
// Shared types and constants for the execute-stage controller.
//   opcode_t / funct_t : instruction fields
//   alu_cmd_t          : ALU command presented to the execute datapath
//   mdu_op_t           : multiply/divide unit operation
//   mdu_state_t        : MDU sequencing state
//   mdu_req_t          : start request handed to the iterative datapath
//   alu_decode()/mdu_decode() : combinational field decoders
package alu_mdu_controller_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_cmd_t;

  typedef enum logic [3:0] {
    MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
    MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO
  } mdu_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} mdu_state_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } mdu_req_t;

  // opcodes
  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_ADDIU = 6'h09;
  localparam opcode_t OP_SLTI  = 6'h0A;
  localparam opcode_t OP_SLTIU = 6'h0B;
  localparam opcode_t OP_ANDI  = 6'h0C;
  localparam opcode_t OP_ORI   = 6'h0D;
  localparam opcode_t OP_XORI  = 6'h0E;
  localparam opcode_t OP_LUI   = 6'h0F;

  // R-type functs
  localparam funct_t F_SLL   = 6'h00;
  localparam funct_t F_SRL   = 6'h02;
  localparam funct_t F_SRA   = 6'h03;
  localparam funct_t F_MFHI  = 6'h10;
  localparam funct_t F_MTHI  = 6'h11;
  localparam funct_t F_MFLO  = 6'h12;
  localparam funct_t F_MTLO  = 6'h13;
  localparam funct_t F_MULT  = 6'h18;
  localparam funct_t F_MULTU = 6'h19;
  localparam funct_t F_DIV   = 6'h1A;
  localparam funct_t F_DIVU  = 6'h1B;
  localparam funct_t F_ADD   = 6'h20;
  localparam funct_t F_ADDU  = 6'h21;
  localparam funct_t F_SUB   = 6'h22;
  localparam funct_t F_SUBU  = 6'h23;
  localparam funct_t F_AND   = 6'h24;
  localparam funct_t F_OR    = 6'h25;
  localparam funct_t F_XOR   = 6'h26;
  localparam funct_t F_NOR   = 6'h27;
  localparam funct_t F_SLT   = 6'h2A;
  localparam funct_t F_SLTU  = 6'h2B;

  function automatic alu_cmd_t alu_decode(opcode_t op, funct_t fn);
    alu_cmd_t c;
    c = ALU_NONE;
    if (op == OP_RTYPE) begin
      case (fn)
        F_ADD, F_ADDU: c = ALU_ADD;
        F_SUB, F_SUBU: c = ALU_SUB;
        F_AND:         c = ALU_AND;
        F_OR:          c = ALU_OR;
        F_XOR:         c = ALU_XOR;
        F_NOR:         c = ALU_NOR;
        F_SLT:         c = ALU_SLT;
        F_SLTU:        c = ALU_SLTU;
        F_SLL:         c = ALU_SLL;
        F_SRL:         c = ALU_SRL;
        F_SRA:         c = ALU_SRA;
        default:       c = ALU_NONE;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU: c = ALU_ADD;
        OP_SLTI:           c = ALU_SLT;
        OP_SLTIU:          c = ALU_SLTU;
        OP_ANDI:           c = ALU_AND;
        OP_ORI:            c = ALU_OR;
        OP_XORI:           c = ALU_XOR;
        OP_LUI:            c = ALU_LUI;
        default:           c = ALU_NONE;
      endcase
    end
    return c;
  endfunction

  function automatic mdu_op_t mdu_decode(opcode_t op, funct_t fn);
    mdu_op_t m;
    m = MDU_NONE;
    if (op == OP_RTYPE) begin
      case (fn)
        F_MULT:  m = MDU_MULT;
        F_MULTU: m = MDU_MULTU;
        F_DIV:   m = MDU_DIV;
        F_DIVU:  m = MDU_DIVU;
        F_MFHI:  m = MDU_MFHI;
        F_MFLO:  m = MDU_MFLO;
        F_MTHI:  m = MDU_MTHI;
        F_MTLO:  m = MDU_MTLO;
        default: m = MDU_NONE;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_mdu_controller_mdu_iter.sv
// Iterative multiply/divide datapath (one result bit per step).
//   load       : capture operands as magnitudes plus result-sign flags
//   step       : advance one shift-add (mul) or restoring-divide (div) bit
//   req        : is_div / is_signed for the captured operation
//   a, b       : rs / rt operands
//   last       : step counter has reached zero
//   res_hi/lo  : sign-corrected HI/LO result (meaningful after the final step)
module alu_mdu_controller_mdu_iter
  import alu_mdu_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  mdu_req_t        req,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc;      // {hi, lo}: mul {partial, multiplier}; div {rem, dividend/quotient}
  logic [XLEN-1:0]   opb;      // multiplicand / divisor magnitude
  logic [CW-1:0]     cnt;
  logic              is_div, neg_hi, neg_lo;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, neg_acc;
  logic              div_ok;

  assign a_neg = req.is_signed & a[XLEN-1];
  assign b_neg = req.is_signed & b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // restoring divide: bring in next dividend bit; subtract divisor if it fits (no borrow)
  assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opb};
  assign div_ok   = ~div_diff[XLEN];
  assign div_nxt  = {div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ok};

  assign last = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
    end else if (load) begin
      is_div <= req.is_div;
      opb    <= mag_b;
      cnt    <= CW'(XLEN-1);
      if (req.is_div && b == '0) begin
        // divide by zero never steps: raw dividend to HI, all ones to LO, no sign fix
        acc    <= {a, {XLEN{1'b1}}};
        neg_hi <= 1'b0;
        neg_lo <= 1'b0;
      end else begin
        acc    <= {{XLEN{1'b0}}, mag_a};
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= req.is_div ? a_neg : (a_neg ^ b_neg);
      end
    end else if (step) begin
      acc <= is_div ? div_nxt : mul_nxt;
      cnt <= cnt - CW'(1);
    end
  end

  // sign fix: product negated as a whole; quotient and remainder independently
  always_comb begin
    neg_acc = -acc;
    if (!is_div) begin
      res_hi = neg_lo ? neg_acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      res_lo = neg_lo ? neg_acc[XLEN-1:0]      : acc[XLEN-1:0];
    end else begin
      res_hi = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      res_lo = neg_lo ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
    end
  end

endmodule

// File: rtl/alu_mdu_controller.sv
// Execute-stage controller: ALU command decode, MDU sequencing, stall, HI/LO.
//   clk, rst_n     : core clock, async active-low reset
//   valid_in       : instruction presented this cycle
//   opcode, funct  : instruction fields
//   rs_val, rt_val : operands
//   flush          : abort in-flight mul/div and drop this cycle's instruction
//   alu_cmd_out    : combinational ALU command
//   stall          : presented MDU op not accepted while busy
//   busy           : mul/div in flight
//   hilo_rd_data   : HI (mfhi) / LO (mflo), else 0
module alu_mdu_controller
  import alu_mdu_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  opcode_t         opcode,
  input  funct_t          funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output alu_cmd_t        alu_cmd_out,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hilo_rd_data
);

  mdu_state_t      state;
  mdu_op_t         mdu_op;
  mdu_req_t        req;
  logic [XLEN-1:0] hi, lo, res_hi, res_lo;
  logic            is_mdu, is_muldiv, accept, start, last;

  assign alu_cmd_out = alu_decode(opcode, funct);
  assign mdu_op      = mdu_decode(opcode, funct);
  assign is_mdu      = (mdu_op != MDU_NONE);
  assign is_muldiv   = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU) ||
                       (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);

  assign req.is_div    = (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
  assign req.is_signed = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);

  assign stall  = valid_in & busy & is_mdu & ~flush;
  assign accept = valid_in & ~flush & ~stall;
  assign start  = accept & ~busy & is_muldiv;

  alu_mdu_controller_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start),
    .step   (state == ST_RUN),
    .req    (req),
    .a      (rs_val),
    .b      (rt_val),
    .last   (last),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= (req.is_div && rt_val == '0) ? ST_FIX : ST_RUN;
            busy  <= 1'b1;
          end
          if (accept && mdu_op == MDU_MTHI) hi <= rs_val;
          if (accept && mdu_op == MDU_MTLO) lo <= rs_val;
        end
        ST_RUN: begin
          if (last) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hilo_rd_data = '0;
    if (valid_in && mdu_op == MDU_MFHI) hilo_rd_data = hi;
    if (valid_in && mdu_op == MDU_MFLO) hilo_rd_data = lo;
  end

endmodule

// File: tb/tb_alu_mdu_controller.sv
module tb_alu_mdu_controller;
  import alu_mdu_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, flush;
  opcode_t     op;
  funct_t      fn;
  logic [31:0] rs, rt, rd;
  alu_cmd_t    cmd;
  logic        stall, busy;

  logic        v8;
  funct_t      fn8;
  logic [7:0]  a8, b8, rd8;
  alu_cmd_t    cmd8;
  logic        stall8, busy8;

  alu_mdu_controller #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid), .opcode(op), .funct(fn),
    .rs_val(rs), .rt_val(rt), .flush(flush), .alu_cmd_out(cmd),
    .stall(stall), .busy(busy), .hilo_rd_data(rd)
  );

  alu_mdu_controller #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(v8), .opcode(OP_RTYPE), .funct(fn8),
    .rs_val(a8), .rt_val(b8), .flush(1'b0), .alu_cmd_out(cmd8),
    .stall(stall8), .busy(busy8), .hilo_rd_data(rd8)
  );

  int n_chk = 0, n_pass = 0;
  logic [31:0] m_hi, m_lo;   // architectural HI/LO as the bench expects them

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input opcode_t o, input funct_t f,
                       input logic [31:0] a, input logic [31:0] b);
    valid = v; op = o; fn = f; rs = a; rt = b;
  endtask

  task automatic idle();
    drive(1'b0, 6'h3F, 6'h00, 32'h0, 32'h0);
  endtask

  // Reference: MIPS mult/div semantics straight from integer arithmetic
  function automatic void ref_mdu(input funct_t f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0;
    case (f)
      F_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      F_MULTU: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_DIVU:  if (b == 0) begin hi = a; lo = '1; end
               else begin lo = a / b; hi = a % b; end
      F_DIV:   if (b == 0) begin hi = a; lo = '1; end
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = 32'h8000_0000; end
               else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      default: ;
    endcase
  endfunction

  // Issue one mul/div, then hammer mflo until accepted and check stall length and results
  task automatic run_mdu(input string nm, input funct_t f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, exp_n;
    ref_mdu(f, a, b, eh, el);
    exp_n = ((f == F_DIV || f == F_DIVU) && b == 0) ? 1 : 33;
    @(negedge clk); drive(1'b1, OP_RTYPE, f, a, b);
    #1 chk({nm, " accept stall"}, stall, 1'b0);
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MFLO, 32'h0, 32'h0);
    #1 chk({nm, " busy"}, busy, 1'b1);
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    chk({nm, " stall cycles"}, n, exp_n);
    chk({nm, " lo"}, rd, el);
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MFHI, 32'h0, 32'h0);
    #1 chk({nm, " hi"}, rd, eh);
    @(negedge clk); idle();
    m_hi = eh; m_lo = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  typedef struct { opcode_t o; funct_t f; alu_cmd_t e; } dec_vec_t;
  dec_vec_t dv [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dv = '{
      '{6'h00, 6'h27, ALU_NOR},  '{6'h0F, 6'h00, ALU_LUI},  '{6'h00, 6'h18, ALU_NONE},
      '{6'h3F, 6'h00, ALU_NONE}, '{6'h00, 6'h20, ALU_ADD},  '{6'h00, 6'h21, ALU_ADD},
      '{6'h00, 6'h23, ALU_SUB},  '{6'h00, 6'h24, ALU_AND},  '{6'h00, 6'h25, ALU_OR},
      '{6'h00, 6'h26, ALU_XOR},  '{6'h00, 6'h2A, ALU_SLT},  '{6'h00, 6'h2B, ALU_SLTU},
      '{6'h00, 6'h00, ALU_SLL},  '{6'h00, 6'h02, ALU_SRL},  '{6'h00, 6'h03, ALU_SRA},
      '{6'h08, 6'h3F, ALU_ADD},  '{6'h0B, 6'h00, ALU_SLTU}, '{6'h0C, 6'h00, ALU_AND},
      '{6'h0E, 6'h00, ALU_XOR},  '{6'h00, 6'h10, ALU_NONE}
    };

    // reset state
    rst_n = 1'b0; flush = 1'b0;
    v8 = 1'b0; fn8 = 6'h00; a8 = 8'h0; b8 = 8'h0;
    drive(1'b1, OP_RTYPE, F_MFHI, 32'h0, 32'h0);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset stall", stall, 1'b0);
    chk("reset hi", rd, 32'h0);
    fn = F_MFLO; #1;
    chk("reset lo", rd, 32'h0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    idle(); rst_n = 1'b1;

    // decode table, valid_in low
    for (int i = 0; i < 20; i++) begin
      op = dv[i].o; fn = dv[i].f; #1;
      chk($sformatf("decode[%0d] %h/%h", i, dv[i].o, dv[i].f), cmd, dv[i].e);
    end
    drive(1'b1, OP_RTYPE, F_ADD, 32'h5, 32'h6); #1;
    chk("rd zero for non-mf", rd, 32'h0);

    // directed arithmetic cases
    run_mdu("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'h7);
    run_mdu("divu 100/7", F_DIVU, 32'd100, 32'd7);
    run_mdu("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'h2);
    run_mdu("div 5/0", F_DIV, 32'h5, 32'h0);
    run_mdu("div min/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mdu("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // randomized against the reference model
    for (int i = 0; i < 30; i++) begin
      funct_t f;
      case ($urandom_range(0, 3))
        0: f = F_MULT; 1: f = F_MULTU; 2: f = F_DIV; default: f = F_DIVU;
      endcase
      run_mdu($sformatf("rand%0d f%h", i, f), f, pick(), pick());
    end

    // mthi/mtlo then immediate readback
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MTLO, 32'h1234_5678, 32'h0);
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MTHI, 32'hA5, 32'h0);
    #1 chk("mflo after mtlo", rd, 32'h0);   // mthi presented, not mfhi
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MFHI, 32'h0, 32'h0);
    #1 chk("mfhi after mthi", rd, 32'hA5);
    m_hi = 32'hA5; m_lo = 32'h1234_5678;

    // flush mid-run
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MULT, 32'h3, 32'h5);   // T
    @(negedge clk); drive(1'b1, OP_RTYPE, F_ADD, 32'h0, 32'h0);    // T+1
    #1 chk("non-mdu no stall", stall, 1'b0);
    chk("alu cmd while busy", cmd, ALU_ADD);
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MFHI, 32'h0, 32'h0);   // T+2
    #1 chk("mdu op stalls", stall, 1'b1);
    idle();
    repeat (8) @(negedge clk);                                     // T+10
    flush = 1'b1;
    #1 chk("busy before flush", busy, 1'b1);
    @(negedge clk); flush = 1'b0;                                  // T+11
    #1 chk("busy after flush", busy, 1'b0);
    drive(1'b1, OP_RTYPE, F_MFHI, 32'h0, 32'h0);
    #1 chk("hi kept after flush", rd, m_hi);
    chk("no stall after flush", stall, 1'b0);
    @(negedge clk); fn = F_MFLO;
    #1 chk("lo kept after flush", rd, m_lo);

    // flush and start in the same idle cycle: no start
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MULT, 32'h3, 32'h5); flush = 1'b1;
    #1 chk("flush masks stall", stall, 1'b0);
    @(negedge clk); flush = 1'b0; idle();
    #1 chk("flush beats start", busy, 1'b0);

    // reset mid-run
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MTHI, 32'h5A, 32'h0);
    @(negedge clk); drive(1'b1, OP_RTYPE, F_MULT, 32'h9, 32'h9);   // T
    @(negedge clk); idle();
    repeat (9) @(negedge clk);                                     // T+10
    #1 chk("busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk("busy drops on reset", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, OP_RTYPE, F_MFHI, 32'h0, 32'h0);
    #1 chk("hi cleared by reset", rd, 32'h0);
    @(negedge clk); fn = F_MFLO;
    #1 chk("lo cleared by reset", rd, 32'h0);
    @(negedge clk); idle();

    // XLEN=8: multu 0xFF*0xFF, readable 10 cycles after accept
    begin
      int n;
      @(negedge clk); v8 = 1'b1; fn8 = F_MULTU; a8 = 8'hFF; b8 = 8'hFF;
      @(negedge clk); fn8 = F_MFLO;
      #1 n = 0;
      while (stall8 && n < 50) begin n++; @(negedge clk); #1; end
      chk("x8 stall cycles", n, 9);
      chk("x8 lo", rd8, 8'h01);
      @(negedge clk); fn8 = F_MFHI;
      #1 chk("x8 hi", rd8, 8'hFE);
      @(negedge clk); v8 = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
